// File: rtl/fp_lane_sanitizer.sv
// Multi-lane low-precision float sanitiser: canonicalises NaN/Inf/zero/subnormal
// lanes in one register stage and tracks sticky flags plus saturating event counters.
module fp_lane_sanitizer #(
    parameter int EXP_W = 2,
    parameter int MAN_W = 3,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [1:0]                       mode,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*(1+EXP_W+MAN_W)-1:0] out_data,
    output logic [3:0]                       out_flags,
    output logic [3:0]                       sticky_flags,
    input  logic                             clr_stats,
    output logic [CNT_W-1:0]                 cnt_nan,
    output logic [CNT_W-1:0]                 cnt_inf,
    output logic [CNT_W-1:0]                 cnt_sub
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int NW = $clog2(LANES + 1);
    localparam int SW = CNT_W + NW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [EXP_W-1:0] MAX_EXP = {{(EXP_W-1){1'b1}}, 1'b0};

    logic [LANES*W-1:0] san_data;
    logic [3:0]         san_flags;
    logic [NW-1:0]      n_nan, n_inf, n_sub;
    logic               accept;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [NW-1:0]    n);
        logic [SW-1:0] s;
        s = SW'(c) + SW'(n);
        return (s > SW'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    always_comb begin
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic [W-1:0]     w;
        logic [W-1:0]     lane_out;
        san_data  = '0;
        san_flags = '0;
        n_nan     = '0;
        n_inf     = '0;
        n_sub     = '0;
        s         = 1'b0;
        e         = '0;
        m         = '0;
        w         = '0;
        lane_out  = '0;
        for (int i = 0; i < LANES; i++) begin
            w        = in_data[i*W +: W];
            s        = w[W-1];
            e        = w[MAN_W +: EXP_W];
            m        = w[MAN_W-1:0];
            lane_out = w;
            if (e == '1) begin
                if (m == '0) begin
                    lane_out     = {s, MAX_EXP, {MAN_W{1'b1}}};
                    san_flags[2] = 1'b1;
                    n_inf        = n_inf + NW'(1);
                end else begin
                    lane_out     = mode[1] ? {s, MAX_EXP, {MAN_W{1'b1}}} : '0;
                    san_flags[3] = 1'b1;
                    n_nan        = n_nan + NW'(1);
                end
            end else if (e == '0) begin
                if (m == '0) begin
                    // -0 collapses to +0 as well
                    lane_out     = '0;
                    san_flags[0] = 1'b1;
                end else begin
                    lane_out     = mode[0] ? '0 : w;
                    san_flags[1] = 1'b1;
                    n_sub        = n_sub + NW'(1);
                end
            end
            san_data[i*W +: W] = lane_out;
        end
    end

    assign in_ready = !rst_n || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_flags    <= '0;
            sticky_flags <= '0;
            cnt_nan      <= '0;
            cnt_inf      <= '0;
            cnt_sub      <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= san_data;
                out_flags <= san_flags;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // a clear in the same cycle as an accept discards that beat's events
            if (clr_stats) begin
                sticky_flags <= '0;
                cnt_nan      <= '0;
                cnt_inf      <= '0;
                cnt_sub      <= '0;
            end else if (accept) begin
                sticky_flags <= sticky_flags | san_flags;
                cnt_nan      <= sat_add(cnt_nan, n_nan);
                cnt_inf      <= sat_add(cnt_inf, n_inf);
                cnt_sub      <= sat_add(cnt_sub, n_sub);
            end
        end
    end

endmodule

// File: tb/tb_fp_lane_sanitizer.sv
// Scoreboard bench for fp_lane_sanitizer: driver pushes model results, a
// separate monitor pops and compares each beat the DUT hands downstream.
module tb_fp_lane_sanitizer;

    localparam int EXP_W = 2;
    localparam int MAN_W = 3;
    localparam int LANES = 4;
    localparam int CNT_W = 4;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int DW    = LANES * W;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, in_ready, out_valid, out_ready, clr_stats;
    logic [1:0]       mode;
    logic [DW-1:0]    in_data, out_data;
    logic [3:0]       out_flags, sticky_flags;
    logic [CNT_W-1:0] cnt_nan, cnt_inf, cnt_sub;

    fp_lane_sanitizer #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .sticky_flags(sticky_flags), .clr_stats(clr_stats),
        .cnt_nan(cnt_nan), .cnt_inf(cnt_inf), .cnt_sub(cnt_sub)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW+3:0] exp_q[$];
    int m_nan, m_inf, m_sub;
    logic [3:0] m_sticky;
    int acc_cnt = 0;
    int pop_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: decode each lane arithmetically and apply the mapping rules.
    function automatic logic [DW+3:0] ref_beat(input logic [DW-1:0] d, input logic [1:0] md,
                                               output int nn, output int ni, output int ns);
        logic [DW-1:0] od;
        logic [3:0]    fl;
        int word, sgn, ex, mn, res, emax, mmax;
        od = '0; fl = '0; nn = 0; ni = 0; ns = 0;
        emax = (1 << EXP_W) - 1;
        mmax = (1 << MAN_W) - 1;
        for (int i = 0; i < LANES; i++) begin
            word = int'((d >> (i * W)) & DW'((1 << W) - 1));
            sgn  = word >> (W - 1);
            ex   = (word >> MAN_W) & emax;
            mn   = word & mmax;
            res  = word;
            if (ex == emax && mn == 0) begin
                res = (sgn << (W - 1)) | ((emax - 1) << MAN_W) | mmax; fl[2] = 1; ni++;
            end else if (ex == emax) begin
                res = md[1] ? ((sgn << (W - 1)) | ((emax - 1) << MAN_W) | mmax) : 0;
                fl[3] = 1; nn++;
            end else if (ex == 0 && mn == 0) begin
                res = 0; fl[0] = 1;
            end else if (ex == 0) begin
                res = md[0] ? 0 : word; fl[1] = 1; ns++;
            end
            od = od | (DW'(res) << (i * W));
        end
        return {fl, od};
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic check_stats();
        chk("cnt_nan", 64'(cnt_nan), 64'(m_nan));
        chk("cnt_inf", 64'(cnt_inf), 64'(m_inf));
        chk("cnt_sub", 64'(cnt_sub), 64'(m_sub));
        chk("sticky_flags", 64'(sticky_flags), 64'(m_sticky));
    endtask

    // One clock of stimulus; returns whether the beat was accepted.
    task automatic cycle(input logic rst, input logic iv, input logic [DW-1:0] d,
                         input logic [1:0] md, input logic ordy, input logic clr,
                         output logic acc);
        int nn, ni, ns;
        logic [DW+3:0] e;
        @(posedge clk); #1;
        check_stats();
        rst_n = rst; in_valid = iv; in_data = d; mode = md; out_ready = ordy; clr_stats = clr;
        #1;
        acc = rst && in_valid && in_ready;
        if (!rst) begin
            exp_q.delete();
            m_nan = 0; m_inf = 0; m_sub = 0; m_sticky = '0;
        end else begin
            e = ref_beat(d, md, nn, ni, ns);
            if (acc) begin
                exp_q.push_back(e);
                acc_cnt++;
            end
            if (clr) begin
                m_nan = 0; m_inf = 0; m_sub = 0; m_sticky = '0;
            end else if (acc) begin
                m_nan = sat(m_nan + nn); m_inf = sat(m_inf + ni); m_sub = sat(m_sub + ns);
                m_sticky = m_sticky | e[DW+3:DW];
            end
        end
    endtask

    // Monitor: pops on every downstream transfer and checks stall behaviour.
    logic          prev_stall = 1'b0;
    logic [DW+3:0] prev_out;
    initial begin
        logic [DW+3:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
                if (prev_stall) begin
                    chk("stall_valid", 64'(out_valid), 64'(1));
                    chk("stall_hold", 64'({out_flags, out_data}), 64'(prev_out));
                end
                if (out_valid && out_ready) begin
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 64'(out_data), 64'(e[DW-1:0]));
                        chk("out_flags", 64'(out_flags), 64'(e[DW+3:DW]));
                    end
                end
            end
            prev_stall = (rst_n === 1'b1) && out_valid && !out_ready;
            prev_out   = {out_flags, out_data};
        end
    end

    function automatic logic [DW-1:0] pack4(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                            input logic [W-1:0] l2, input logic [W-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    initial begin
        logic a;
        int a0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0; out_ready = 1'b0; clr_stats = 1'b0;
        m_nan = 0; m_inf = 0; m_sub = 0; m_sticky = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_flags", 64'(out_flags), 64'(0));
        check_stats();

        // Mixed NaN / -Inf / normal / -0 beat, default mode
        cycle(1, 1, pack4(6'b011001, 6'b111000, 6'b001010, 6'b100000), 2'b00, 1, 0, a);
        chk("first_accept", 64'(a), 64'(1));
        cycle(1, 0, '0, 2'b00, 1, 0, a);
        chk("dir_out_data", 64'(out_data), 64'(pack4(6'b000000, 6'b110111, 6'b001010, 6'b000000)));
        chk("dir_out_flags", 64'(out_flags), 64'(4'b1101));
        chk("dir_cnt_nan", 64'(cnt_nan), 64'(1));
        chk("dir_cnt_inf", 64'(cnt_inf), 64'(1));

        // NaN policy and subnormal flushing
        cycle(1, 1, pack4(6'b111011, 6'b000101, 6'b000101, 6'b010000), 2'b10, 1, 0, a);
        cycle(1, 1, pack4(6'b000101, 6'b010000, 6'b010000, 6'b010000), 2'b01, 1, 0, a);
        cycle(1, 1, pack4(6'b000101, 6'b010000, 6'b010000, 6'b010000), 2'b00, 1, 0, a);
        cycle(1, 0, '0, 2'b00, 1, 0, a);

        // Stall for 5 cycles with a new beat waiting
        cycle(1, 1, pack4(6'b001001, 6'b111000, 6'b000001, 6'b011111), 2'b00, 0, 0, a);
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, pack4(6'b011010, 6'b011010, 6'b000011, 6'b100000), 2'b11, 0, 0, a);
            chk("stall_in_ready", 64'(in_ready), 64'(0));
        end
        chk("stall_no_accept", 64'(acc_cnt - a0), 64'(0));

        // Release: queued beat and full-throughput streaming
        a0 = acc_cnt;
        for (int i = 0; i < 8; i++)
            cycle(1, 1, DW'($urandom), 2'($urandom), 1, 0, a);
        chk("throughput_accepts", 64'(acc_cnt - a0), 64'(8));
        a0 = pop_cnt;
        cycle(1, 0, '0, 2'b00, 1, 0, a);
        cycle(1, 0, '0, 2'b00, 1, 0, a);

        // Saturation: five all-NaN beats
        cycle(1, 0, '0, 2'b00, 1, 1, a);
        for (int i = 0; i < 6; i++)
            cycle(1, (i < 5), {LANES{6'b011001}}, 2'b00, 1, 0, a);
        chk("sat_cnt_nan", 64'(cnt_nan), 64'(MAXC));
        cycle(1, 0, '0, 2'b00, 1, 0, a);
        chk("sat_hold", 64'(cnt_nan), 64'(MAXC));

        // Clear wins over a simultaneously accepted all-Inf beat
        cycle(1, 1, {LANES{6'b011000}}, 2'b00, 1, 1, a);
        cycle(1, 0, '0, 2'b00, 1, 0, a);
        chk("clr_cnt_inf", 64'(cnt_inf), 64'(0));
        chk("clr_sticky", 64'(sticky_flags), 64'(0));
        chk("clr_out_data", 64'(out_data), 64'({LANES{6'b010111}}));

        // Reset during a stall
        cycle(1, 1, {LANES{6'b111010}}, 2'b10, 0, 0, a);
        cycle(1, 1, {LANES{6'b000111}}, 2'b00, 0, 0, a);
        cycle(0, 0, '0, 2'b00, 0, 0, a);
        cycle(1, 0, '0, 2'b00, 1, 0, a);
        chk("rst_stall_valid", 64'(out_valid), 64'(0));
        chk("rst_stall_nan", 64'(cnt_nan), 64'(0));

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), DW'($urandom),
                  2'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), a);
        end

        for (int i = 0; i < 4; i++)
            cycle(1, 0, '0, 2'b00, 1, 0, a);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
